// File: rtl/modulo.sv
// Sequential unsigned modulo: output_tdata = dividend mod divisor.
// Restoring shift-subtract, one quotient bit per clock.
// Operands arrive on two independent valid/ready streams; the remainder
// leaves on a valid/ready output stream.
// Optional build macro MODULO_QUOTIENT_EN adds output_quotient_tdata.
module modulo #(
    parameter int unsigned SIZE = 128
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [SIZE-1:0] input_dividen_tdata,
    input  logic            input_dividen_tvalid,
    output logic            input_dividen_tready,
    input  logic [SIZE-1:0] input_divisor_tdata,
    input  logic            input_divisor_tvalid,
    output logic            input_divisor_tready,
    output logic [SIZE-1:0] output_tdata,
    output logic            output_tvalid,
`ifdef MODULO_QUOTIENT_EN
    output logic [SIZE-1:0] output_quotient_tdata,
`endif
    input  logic            output_tready
);

    localparam int unsigned CW = $clog2(SIZE + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [SIZE-1:0]   dividen_q, dividen_d;
    logic [SIZE-1:0]   divisor_q, divisor_d;
    logic              dividen_full_q, dividen_full_d;
    logic              divisor_full_q, divisor_full_d;
    logic              dividen_ready_q, dividen_ready_d;
    logic              divisor_ready_q, divisor_ready_d;
    // Partial remainder is always below the divisor between iterations,
    // so SIZE bits hold it; the extra bit only exists in rem_shift.
    logic [SIZE-1:0]   rem_q, rem_d;
    // Dividend bits shift out of the top while quotient bits fill the bottom.
    logic [SIZE-1:0]   shift_q, shift_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [SIZE-1:0]   out_data_q, out_data_d;
    logic              out_valid_q, out_valid_d;
`ifdef MODULO_QUOTIENT_EN
    logic [SIZE-1:0]   out_quo_q, out_quo_d;
`endif

    logic [SIZE:0]     rem_shift;
    logic [SIZE:0]     rem_sub;
    logic              q_bit;
    logic              dividen_hs;
    logic              divisor_hs;

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= IDLE;
            dividen_q       <= '0;
            divisor_q       <= '0;
            dividen_full_q  <= 1'b0;
            divisor_full_q  <= 1'b0;
            dividen_ready_q <= 1'b0;
            divisor_ready_q <= 1'b0;
            rem_q           <= '0;
            shift_q         <= '0;
            cnt_q           <= '0;
            out_data_q      <= '0;
            out_valid_q     <= 1'b0;
`ifdef MODULO_QUOTIENT_EN
            out_quo_q       <= '0;
`endif
        end else begin
            state_q         <= state_d;
            dividen_q       <= dividen_d;
            divisor_q       <= divisor_d;
            dividen_full_q  <= dividen_full_d;
            divisor_full_q  <= divisor_full_d;
            dividen_ready_q <= dividen_ready_d;
            divisor_ready_q <= divisor_ready_d;
            rem_q           <= rem_d;
            shift_q         <= shift_d;
            cnt_q           <= cnt_d;
            out_data_q      <= out_data_d;
            out_valid_q     <= out_valid_d;
`ifdef MODULO_QUOTIENT_EN
            out_quo_q       <= out_quo_d;
`endif
        end
    end

    // Next-state, operand capture and one restoring-division step per cycle.
    always_comb begin
        state_d        = state_q;
        dividen_d      = dividen_q;
        divisor_d      = divisor_q;
        dividen_full_d = dividen_full_q;
        divisor_full_d = divisor_full_q;
        rem_d          = rem_q;
        shift_d        = shift_q;
        cnt_d          = cnt_q;
        out_data_d     = out_data_q;
        out_valid_d    = out_valid_q;
`ifdef MODULO_QUOTIENT_EN
        out_quo_d      = out_quo_q;
`endif

        rem_shift  = {rem_q, shift_q[SIZE-1]};
        rem_sub    = rem_shift - {1'b0, divisor_q};
        q_bit      = (rem_shift >= {1'b0, divisor_q});
        dividen_hs = input_dividen_tvalid && dividen_ready_q;
        divisor_hs = input_divisor_tvalid && divisor_ready_q;

        unique case (state_q)
            IDLE: begin
                if (dividen_hs) begin
                    dividen_d      = input_dividen_tdata;
                    dividen_full_d = 1'b1;
                end
                if (divisor_hs) begin
                    divisor_d      = input_divisor_tdata;
                    divisor_full_d = 1'b1;
                end
                // Start as soon as both operands are held, including the capture edge.
                if (dividen_full_d && divisor_full_d) begin
                    state_d = CALC;
                    rem_d   = '0;
                    shift_d = dividen_d;
                    cnt_d   = CW'(SIZE);
                end
            end
            CALC: begin
                if (cnt_q != '0) begin
                    rem_d   = q_bit ? SIZE'(rem_sub) : SIZE'(rem_shift);
                    shift_d = {shift_q[SIZE-2:0], q_bit};
                    cnt_d   = cnt_q - CW'(1);
                end else begin
                    state_d     = DONE;
                    out_data_d  = rem_q;
                    out_valid_d = 1'b1;
`ifdef MODULO_QUOTIENT_EN
                    out_quo_d   = shift_q;
`endif
                end
            end
            DONE: begin
                if (output_tready) begin
                    state_d        = IDLE;
                    out_valid_d    = 1'b0;
                    dividen_full_d = 1'b0;
                    divisor_full_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        dividen_ready_d = (state_d == IDLE) && !dividen_full_d;
        divisor_ready_d = (state_d == IDLE) && !divisor_full_d;
    end

    assign input_dividen_tready = dividen_ready_q;
    assign input_divisor_tready = divisor_ready_q;
    assign output_tdata         = out_data_q;
    assign output_tvalid        = out_valid_q;
`ifdef MODULO_QUOTIENT_EN
    assign output_quotient_tdata = out_quo_q;
`endif

endmodule

// File: tb/tb_modulo.sv
// Directed testbench for modulo (SIZE=128).
`timescale 1ns/1ps
module tb_modulo;

    localparam int unsigned SIZE = 128;

    logic            clk = 1'b0;
    logic            rst;
    logic [SIZE-1:0] input_dividen_tdata;
    logic            input_dividen_tvalid;
    logic            input_dividen_tready;
    logic [SIZE-1:0] input_divisor_tdata;
    logic            input_divisor_tvalid;
    logic            input_divisor_tready;
    logic [SIZE-1:0] output_tdata;
    logic            output_tvalid;
    logic            output_tready;
`ifdef MODULO_QUOTIENT_EN
    logic [SIZE-1:0] output_quotient_tdata;
`endif

    int vec_cnt = 0;
    int err_cnt = 0;

    modulo #(.SIZE(SIZE)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .input_dividen_tdata  (input_dividen_tdata),
        .input_dividen_tvalid (input_dividen_tvalid),
        .input_dividen_tready (input_dividen_tready),
        .input_divisor_tdata  (input_divisor_tdata),
        .input_divisor_tvalid (input_divisor_tvalid),
        .input_divisor_tready (input_divisor_tready),
        .output_tdata         (output_tdata),
        .output_tvalid        (output_tvalid),
`ifdef MODULO_QUOTIENT_EN
        .output_quotient_tdata(output_quotient_tdata),
`endif
        .output_tready        (output_tready)
    );

    always #5 clk = ~clk;

    // Present both operands from a negedge; returns at the negedge after both are taken.
    task automatic start_op(input logic [SIZE-1:0] a, input logic [SIZE-1:0] b, output bit ok);
        bit hd, hs;
        int n;
        input_dividen_tdata  = a;
        input_divisor_tdata  = b;
        input_dividen_tvalid = 1'b1;
        input_divisor_tvalid = 1'b1;
        n = 0;
        while ((input_dividen_tvalid || input_divisor_tvalid) && n < 20) begin
            hd = input_dividen_tvalid && input_dividen_tready;
            hs = input_divisor_tvalid && input_divisor_tready;
            @(posedge clk);
            #1;
            if (hd) input_dividen_tvalid = 1'b0;
            if (hs) input_divisor_tvalid = 1'b0;
            n++;
            @(negedge clk);
        end
        ok = !(input_dividen_tvalid || input_divisor_tvalid);
        input_dividen_tvalid = 1'b0;
        input_divisor_tvalid = 1'b0;
    endtask

    // Count rising edges from the current negedge until output_tvalid is seen.
    task automatic wait_result(output int lat);
        lat = 0;
        while (!output_tvalid && lat < 400) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst                  = 1'b0;
        input_dividen_tdata  = '0;
        input_dividen_tvalid = 1'b0;
        input_divisor_tdata  = '0;
        input_divisor_tvalid = 1'b0;
        output_tready        = 1'b0;
        repeat (3) @(negedge clk);
        vec_cnt++;
        if (output_tvalid !== 1'b0 || output_tdata !== '0)
            begin err_cnt++; $display("FAIL reset_out: got valid=%0b data=%0d, want 0/0", output_tvalid, output_tdata); end
        vec_cnt++;
        if ({input_dividen_tready, input_divisor_tready} !== 2'b00)
            begin err_cnt++; $display("FAIL reset_ready: got %b, want 00", {input_dividen_tready, input_divisor_tready}); end
        rst = 1'b1;
        @(negedge clk);
        vec_cnt++;
        if ({input_dividen_tready, input_divisor_tready} !== 2'b11)
            begin err_cnt++; $display("FAIL reset_release_ready: got %b, want 11", {input_dividen_tready, input_divisor_tready}); end
    endtask

    task automatic test_basic();
        bit ok;
        int lat;
        output_tready = 1'b1;
        start_op(128'd143563, 128'd2137, ok);
        vec_cnt++;
        if (!ok) begin err_cnt++; $display("FAIL basic_capture: operands not accepted, want accepted"); end
        wait_result(lat);
        vec_cnt++;
        if (lat !== 129) begin err_cnt++; $display("FAIL basic_latency: got %0d, want 129", lat); end
        vec_cnt++;
        if (output_tdata !== 128'd384) begin err_cnt++; $display("FAIL basic_rem: got %0d, want 384", output_tdata); end
`ifdef MODULO_QUOTIENT_EN
        vec_cnt++;
        if (output_quotient_tdata !== 128'd67) begin err_cnt++; $display("FAIL basic_quo: got %0d, want 67", output_quotient_tdata); end
`endif
        @(posedge clk);
        @(negedge clk);
        vec_cnt++;
        if (output_tvalid !== 1'b0 || {input_dividen_tready, input_divisor_tready} !== 2'b11)
            begin err_cnt++; $display("FAIL basic_after: got valid=%0b ready=%b, want 0/11", output_tvalid, {input_dividen_tready, input_divisor_tready}); end
    endtask

    task automatic test_staggered();
        int lat;
        output_tready        = 1'b1;
        input_divisor_tdata  = 128'd7;
        input_divisor_tvalid = 1'b1;
        @(posedge clk);
        #1;
        input_divisor_tvalid = 1'b0;
        @(negedge clk);
        vec_cnt++;
        if ({input_dividen_tready, input_divisor_tready} !== 2'b10)
            begin err_cnt++; $display("FAIL stag_ready_drop: got %b, want 10", {input_dividen_tready, input_divisor_tready}); end
        repeat (4) @(posedge clk);
        @(negedge clk);
        vec_cnt++;
        if ({input_dividen_tready, input_divisor_tready, output_tvalid} !== 3'b100)
            begin err_cnt++; $display("FAIL stag_wait: got ready/valid=%b, want 100", {input_dividen_tready, input_divisor_tready, output_tvalid}); end
        input_dividen_tdata  = 128'd100;
        input_dividen_tvalid = 1'b1;
        @(posedge clk);
        #1;
        input_dividen_tvalid = 1'b0;
        @(negedge clk);
        wait_result(lat);
        vec_cnt++;
        if (lat !== 129) begin err_cnt++; $display("FAIL stag_latency: got %0d, want 129", lat); end
        vec_cnt++;
        if (output_tdata !== 128'd2) begin err_cnt++; $display("FAIL stag_rem: got %0d, want 2", output_tdata); end
`ifdef MODULO_QUOTIENT_EN
        vec_cnt++;
        if (output_quotient_tdata !== 128'd14) begin err_cnt++; $display("FAIL stag_quo: got %0d, want 14", output_quotient_tdata); end
`endif
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        bit ok;
        int lat;
        output_tready = 1'b0;
        start_op(128'd1000, 128'd999, ok);
        wait_result(lat);
        vec_cnt++;
        if (lat !== 129 || output_tdata !== 128'd1)
            begin err_cnt++; $display("FAIL bp_result: got lat=%0d rem=%0d, want 129/1", lat, output_tdata); end
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            @(negedge clk);
            vec_cnt++;
            if (output_tvalid !== 1'b1 || output_tdata !== 128'd1 || {input_dividen_tready, input_divisor_tready} !== 2'b00)
                begin err_cnt++; $display("FAIL bp_hold[%0d]: got valid=%0b rem=%0d ready=%b, want 1/1/00", i, output_tvalid, output_tdata, {input_dividen_tready, input_divisor_tready}); end
        end
        output_tready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        vec_cnt++;
        if (output_tvalid !== 1'b0 || output_tdata !== 128'd1 || {input_dividen_tready, input_divisor_tready} !== 2'b11)
            begin err_cnt++; $display("FAIL bp_release: got valid=%0b rem=%0d ready=%b, want 0/1/11", output_tvalid, output_tdata, {input_dividen_tready, input_divisor_tready}); end
    endtask

    task automatic test_corners();
        logic [SIZE-1:0] va [4];
        logic [SIZE-1:0] vb [4];
        logic [SIZE-1:0] vr [4];
        logic [SIZE-1:0] vq [4];
        logic [SIZE-1:0] all1;
        bit ok;
        int lat;
        all1 = '1;
        va[0] = 128'd5; vb[0] = 128'd0;  vr[0] = 128'd5; vq[0] = all1;
        va[1] = 128'd3; vb[1] = 128'd10; vr[1] = 128'd3; vq[1] = 128'd0;
        va[2] = all1;   vb[2] = all1;    vr[2] = 128'd0; vq[2] = 128'd1;
        va[3] = all1;   vb[3] = 128'd2;  vr[3] = 128'd1; vq[3] = all1 >> 1;
        output_tready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            start_op(va[i], vb[i], ok);
            wait_result(lat);
            vec_cnt++;
            if (!ok || lat !== 129 || output_tdata !== vr[i])
                begin err_cnt++; $display("FAIL corner%0d: got ok=%0b lat=%0d rem=%0h, want 1/129/%0h", i, ok, lat, output_tdata, vr[i]); end
`ifdef MODULO_QUOTIENT_EN
            vec_cnt++;
            if (output_quotient_tdata !== vq[i])
                begin err_cnt++; $display("FAIL corner%0d_quo: got %0h, want %0h", i, output_quotient_tdata, vq[i]); end
`endif
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int lat;
        bit seen;
        output_tready = 1'b1;
        start_op(128'd143563, 128'd2137, ok);
        repeat (50) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        vec_cnt++;
        if (output_tvalid !== 1'b0 || output_tdata !== '0 || {input_dividen_tready, input_divisor_tready} !== 2'b00)
            begin err_cnt++; $display("FAIL rstmid_abort: got valid=%0b rem=%0d ready=%b, want 0/0/00", output_tvalid, output_tdata, {input_dividen_tready, input_divisor_tready}); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        vec_cnt++;
        if ({input_dividen_tready, input_divisor_tready} !== 2'b11)
            begin err_cnt++; $display("FAIL rstmid_ready: got %b, want 11", {input_dividen_tready, input_divisor_tready}); end
        seen = 1'b0;
        repeat (150) begin
            @(negedge clk);
            if (output_tvalid) seen = 1'b1;
        end
        vec_cnt++;
        if (seen) begin err_cnt++; $display("FAIL rstmid_no_partial: got valid=1 after abort, want 0"); end
        start_op(128'd143563, 128'd2137, ok);
        wait_result(lat);
        vec_cnt++;
        if (!ok || lat !== 129 || output_tdata !== 128'd384)
            begin err_cnt++; $display("FAIL rstmid_fresh: got ok=%0b lat=%0d rem=%0d, want 1/129/384", ok, lat, output_tdata); end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        bit ok;
        int lat;
        output_tready = 1'b1;
        start_op(128'd143563, 128'd2137, ok);
        input_dividen_tdata  = 128'd1000000;
        input_divisor_tdata  = 128'd997;
        input_dividen_tvalid = 1'b1;
        input_divisor_tvalid = 1'b1;
        wait_result(lat);
        vec_cnt++;
        if (lat !== 129 || output_tdata !== 128'd384)
            begin err_cnt++; $display("FAIL b2b_first: got lat=%0d rem=%0d, want 129/384", lat, output_tdata); end
        vec_cnt++;
        if ({input_dividen_tready, input_divisor_tready} !== 2'b00)
            begin err_cnt++; $display("FAIL b2b_blocked: got ready=%b during first op, want 00", {input_dividen_tready, input_divisor_tready}); end
        @(posedge clk);
        @(negedge clk);
        vec_cnt++;
        if ({input_dividen_tready, input_divisor_tready} !== 2'b11)
            begin err_cnt++; $display("FAIL b2b_reopen: got ready=%b after handshake, want 11", {input_dividen_tready, input_divisor_tready}); end
        start_op(128'd1000000, 128'd997, ok);
        wait_result(lat);
        vec_cnt++;
        if (!ok || lat !== 129 || output_tdata !== 128'd9)
            begin err_cnt++; $display("FAIL b2b_second: got ok=%0b lat=%0d rem=%0d, want 1/129/9", ok, lat, output_tdata); end
`ifdef MODULO_QUOTIENT_EN
        vec_cnt++;
        if (output_quotient_tdata !== 128'd1003)
            begin err_cnt++; $display("FAIL b2b_quo: got %0d, want 1003", output_quotient_tdata); end
`endif
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_staggered();
        test_backpressure();
        test_corners();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/modulo.md
Name: modulo

Overview:
- Sequential unsigned modulo unit: computes dividend mod divisor over SIZE-bit operands.
- Uses a restoring shift-subtract algorithm, one quotient bit per clock.
- Operands arrive on two independent valid/ready streams; the remainder leaves on a valid/ready output stream.
- Serves as the modular-reduction primitive for the ElGamal datapath (modular multiply/exponentiate stages).

Parameters:
- SIZE, 128, operand and result width in bits (>= 2).

Ports:
- clk  input  1  system clock, rising-edge active.
- rst  input  1  asynchronous, active-low reset (0 = reset asserted).
- input_dividen_tdata  input  SIZE  dividend, unsigned.
- input_dividen_tvalid  input  1  dividend valid.
- input_dividen_tready  output  1  dividend accepted when high together with tvalid.
- input_divisor_tdata  input  SIZE  divisor, unsigned.
- input_divisor_tvalid  input  1  divisor valid.
- input_divisor_tready  output  1  divisor accepted when high together with tvalid.
- output_tdata  output  SIZE  remainder.
- output_tvalid  output  1  remainder valid.
- output_tready  input  1  downstream ready.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; both operand holding registers empty.
  - All tready outputs 0; output_tvalid=0; output_tdata=0.
  - Internal remainder, quotient and counter cleared.
  - Reset mid-calculation aborts the operation; no partial result is ever presented.
- Ready rules: input_X_tready=1 only in IDLE with holding register X empty and rst deasserted.
- Operand capture: a handshake (tvalid & tready at a rising edge) loads register X and marks it full.
  - The two operands may arrive in the same cycle or in either order, any number of cycles apart.
  - A full register drops its tready on the following cycle.
- State machine: IDLE -> CALC -> DONE -> IDLE.
- IDLE -> CALC: on the first edge at which both registers are full (this edge is also allowed to be the capture edge of the second operand).
  - Entry actions: R (SIZE+1 bits) = 0; shift register = dividend; counter = SIZE.
- CALC, one iteration per edge:
  - R = {R[SIZE-1:0], next dividend MSB}.
  - If R >= {1'b0, divisor}: R = R - divisor, quotient bit = 1; otherwise quotient bit = 0.
  - Counter decrements each iteration.
  - After exactly SIZE iterations: state=DONE, output_tdata=R[SIZE-1:0], output_tvalid=1.
- Latency: output_tvalid rises SIZE+1 rising edges after the edge at which the second operand is captured.
- DONE:
  - output_tdata and output_tvalid held stable until output_tready=1 at a rising edge.
  - On that edge: output_tvalid=0, holding registers emptied, state=IDLE; tready outputs high on the next cycle.
  - output_tready is ignored outside DONE.
- Throughput: one operation in flight; no new operands accepted during CALC or DONE.
- Divisor = 0: no special path; the algorithm yields remainder = dividend (quotient all ones) with the normal latency.
- Dividend < divisor: remainder = dividend, normal latency.
- output_tdata is registered; it keeps its last value after the handshake until the next result is loaded.

Optional Feature:
- Macro: MODULO_QUOTIENT_EN.
- Defined: adds output port output_quotient_tdata (output, SIZE). It carries the quotient, is valid and stable under the same output_tvalid/output_tready handshake, and resets to 0.
- Undefined: the port does not exist and quotient storage is optimised away. Remainder behaviour is identical in both builds.

Test Plan:
- Basic: SIZE=128, dividend=143563, divisor=2137, both valid in the same cycle, output_tready=1 -> output_tvalid after 129 edges, output_tdata=384 (quotient 67 with MODULO_QUOTIENT_EN); tready outputs return to 1 afterwards.
- Staggered operands: divisor 7 presented 5 cycles before dividend 100 -> divisor_tready drops after capture; result 2 appears 129 edges after dividend capture.
- Backpressure: dividend=1000, divisor=999, output_tready=0 for 20 cycles after valid -> output_tvalid and output_tdata=1 held stable; tready outputs stay 0; completes on the output_tready edge.
- Corners:
  - dividend=5, divisor=0 -> remainder 5.
  - dividend=3, divisor=10 -> 3.
  - dividend=2^128-1, divisor=2^128-1 -> 0.
  - dividend=2^128-1, divisor=2 -> 1.
- Reset mid-calculation: assert rst=0 at iteration 50 -> output_tvalid=0 and tready outputs=0 immediately; after release both tready outputs=1, and a fresh operation 143563 mod 2137 returns 384.
- Back-to-back: two operations with output_tready tied to 1 -> second operands accepted only after the first result handshake; both results correct.
